// File: rtl/pixel_stream_rx.sv
// HSYNC/VSYNC pixel receiver: frames bytes into tagged pixels, buffers them in a
// first-word-fall-through FIFO and re-emits them on valid/ready. Optional frame checksum: PIX_RX_CHECKSUM_EN.
module pixel_stream_rx #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int DEPTH  = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] data,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow
`ifdef PIX_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t            state, state_nx;
  logic              vs_q;
  logic              rise;
  logic [CW-1:0]     col, col_eff;
  logic [RW-1:0]     row, row_eff;
  logic              at_eol, at_last_row, at_eof;
  logic              in_frame, pix_wr, stray, premature;

  logic [10:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, rd, wr_ok, ovf_set;
  logic [10:0]       wr_word, head;

  assign rise = VSYNC & ~vs_q;

  // A VSYNC rise takes effect before any byte in the same cycle, so that byte is pixel (0,0).
  assign col_eff     = rise ? '0 : col;
  assign row_eff     = rise ? '0 : row;
  assign at_eol      = (col_eff == CW'(WIDTH - 1));
  assign at_last_row = (row_eff == RW'(HEIGHT - 1));
  assign at_eof      = at_eol && at_last_row;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
      vs_q  <= 1'b0;
    end else begin
      state <= state_nx;
      vs_q  <= VSYNC;
    end
  end

  always_comb begin
    state_nx = state;
    if (pix_wr && at_eof) begin
      state_nx = S_DONE;
    end else if (rise) begin
      state_nx = S_ACTIVE;
    end
  end

  always_comb begin
    in_frame  = rise || (state == S_ACTIVE);
    pix_wr    = HSYNC && in_frame;
    stray     = HSYNC && !in_frame;
    premature = rise && (state == S_ACTIVE);
  end

  // Position counters advance even when the FIFO drops the byte, keeping the frame aligned.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      col        <= '0;
      row        <= '0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (pix_wr) begin
        if (at_eol) begin
          col <= '0;
          row <= at_last_row ? '0 : row_eff + 1'b1;
        end else begin
          col <= col_eff + 1'b1;
          row <= row_eff;
        end
      end else if (rise) begin
        col <= '0;
        row <= '0;
      end
      if (rise) begin
        frame_err <= premature;
      end else if (stray) begin
        frame_err <= 1'b1;
      end
      frame_done <= pix_wr && at_eof;
    end
  end

  assign wr_word = {at_eof, at_eol, (col_eff == '0) && (row_eff == '0), data};
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd      = pix_valid && pix_ready;
  assign wr_ok   = pix_wr && (!full || rd);
  assign ovf_set = pix_wr && full && !rd;

  always_ff @(posedge HCLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // Outputs are gated by occupancy so an empty (or just reset) FIFO presents zeros.
  assign head      = mem[rd_ptr];
  assign pix_valid = (count != '0);
  assign pix_data  = pix_valid ? head[7:0] : 8'd0;
  assign pix_sof   = pix_valid & head[8];
  assign pix_eol   = pix_valid & head[9];
  assign pix_eof   = pix_valid & head[10];

`ifdef PIX_RX_CHECKSUM_EN
  logic [15:0] sum_acc, sum_nx;

  always_comb begin
    sum_nx = (rise ? 16'd0 : sum_acc) + (wr_ok ? {8'd0, data} : 16'd0);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sum_acc   <= 16'd0;
      frame_sum <= 16'd0;
    end else begin
      if (rise || wr_ok) begin
        sum_acc <= sum_nx;
      end
      if (pix_wr && at_eof) begin
        frame_sum <= sum_nx;
      end
    end
  end
`endif

endmodule

// File: doc/pixel_stream_rx.md
Name: pixel_stream_rx

Overview:
- Receive end of the HSYNC/VSYNC pixel stream produced by the image source, i.e. the `VSYNC`/`HSYNC`/`data` bus driven upstream.
- Qualifies bytes with HSYNC and tracks column/row position against the configured frame size.
- Buffers tagged pixels in a small FIFO and re-emits them on a valid/ready stream for downstream consumers that can apply backpressure.
- Flags framing errors and FIFO overflow.

Parameters:
- WIDTH, 768, pixels per line
- HEIGHT, 512, lines per frame
- DEPTH, 16, FIFO entries (power of two, >= 4)

Ports:
- HCLK  in  1  system clock, all logic on rising edge
- HRESET  in  1  asynchronous active-high reset
- VSYNC  in  1  frame-start marker from source; rising edge opens a frame
- HSYNC  in  1  byte-valid qualifier for data
- data  in  8  pixel byte, sampled when HSYNC=1
- pix_data  out  8  buffered pixel
- pix_valid  out  1  pix_data/tags valid
- pix_ready  in  1  downstream accepts when pix_valid&pix_ready
- pix_sof  out  1  tag: first pixel of frame (col 0, row 0)
- pix_eol  out  1  tag: last pixel of a line (col WIDTH-1)
- pix_eof  out  1  tag: last pixel of frame
- frame_done  out  1  one-cycle pulse when the eof pixel is written into the FIFO
- frame_err  out  1  sticky framing error, cleared at next VSYNC rising edge
- overflow  out  1  sticky, cleared only by reset

Behaviour:
- Reset (async, HRESET=1):
  - FIFO emptied; pix_valid=0; pix_data=0; tags=0.
  - frame_done=0, frame_err=0, overflow=0.
  - col=0, row=0, state=IDLE.
- VSYNC is edge-detected with a registered copy (vs_q); rise = VSYNC & ~vs_q.
- State IDLE: waits for rise, then moves to ACTIVE with col=row=0 and frame_err cleared. HSYNC=1 in IDLE sets frame_err and the byte is discarded.
- State ACTIVE: each HSYNC=1 cycle writes {eof,eol,sof,data} to the FIFO.
  - col increments; at col==WIDTH-1, col wraps to 0 and row increments.
  - At col==WIDTH-1 && row==HEIGHT-1: eof tag set, frame_done pulses the next cycle, state goes to DONE.
- State DONE: rise goes to ACTIVE (new frame). HSYNC=1 sets frame_err and the byte is discarded.
- Rise in ACTIVE (premature frame) sets frame_err and restarts counters at 0; the pending partial frame is not padded.
- Rise and HSYNC in the same cycle: the rise is processed first, so the byte is pixel (0,0) with sof=1.
- FIFO is synchronous with a write pointer, a read pointer and a count of log2(DEPTH)+1 bits.
  - Write-to-output latency: first-word-fall-through, so pix_valid rises the cycle after the write into an empty FIFO.
  - Simultaneous read and write when full: the read frees the slot and the write is accepted, with no overflow.
  - Write when full with no read: the byte is dropped and overflow is set. col/row still advance so framing stays aligned.
  - Read when empty: impossible, since pix_valid=0.
- Output held stable while pix_valid=1 and pix_ready=0.
- Reset mid-frame: everything returns to reset values immediately; no partial output.
- Counters wide enough for WIDTH-1 and HEIGHT-1 ($clog2).

Optional Feature:
- PIX_RX_CHECKSUM_EN defined:
  - Adds output frame_sum[15:0], a modulo-2^16 sum of every byte written to the FIFO in the current frame.
  - The sum is cleared on rise and latched into frame_sum in the same cycle frame_done pulses.
  - Reset value 0; dropped (overflow) bytes are excluded.
- Undefined: no port, no adder logic.

Test Plan:
- Reset, then WIDTH=4/HEIGHT=2, VSYNC pulse, then 8 HSYNC bytes 0x10..0x17 with pix_ready=1.
  - Outputs 0x10..0x17 in order.
  - sof on 0x10; eol on 0x13 and 0x17; eof on 0x17.
  - frame_done pulses once; frame_err=0.
- DEPTH=4, pix_ready=0, 6 bytes streamed: 4 buffered, overflow=1. Then pix_ready=1 drains exactly 4 bytes and pix_valid drops to 0.
- VSYNC rises after 5 of 8 pixels: frame_err=1. The next byte carries sof=1; a clean following frame clears frame_err at its VSYNC.
- HSYNC with byte 0xAA before any VSYNC: frame_err=1, nothing output.
- Assert HRESET mid-frame with the FIFO holding 3 entries: pix_valid=0 the same cycle and all flags 0. A fresh frame then works normally.
- With PIX_RX_CHECKSUM_EN, frame bytes 0xFF x8: frame_sum=0x07F8 on the frame_done cycle.
